// File: rtl/mem_sync_top.sv
// Per-bank row-cache synchroniser: maps each bank's open DRAM row to a cache slot,
// stalling on a miss until the external copy engine pulses sync for that bank.

module mem_sync_unit #(
  parameter int CHWIDTH   = 6,
  parameter int ADDRWIDTH = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDRWIDTH-1:0] row_id,
  input  logic [4:0]           bank_fsm,
  input  logic                 sync,
  output logic [CHWIDTH-1:0]   c_row_id,
  output logic                 in_alloc
);
  localparam int CHROWS = 2**CHWIDTH;
  localparam logic [4:0] WRITING = 5'b10010;
  localparam logic [4:0] READING = 5'b01011;

  typedef enum logic [1:0] {IDLE, ALLOC, SYNCED} state_t;

  state_t                state, state_nxt;
  logic [ADDRWIDTH-1:0]  tags [CHROWS];
  logic [CHROWS-1:0]     valid;
  logic [CHWIDTH-1:0]    ptr;
  logic                  active, hit, do_lookup, ptr_inc;
  logic [CHWIDTH-1:0]    hit_idx;

  assign active   = (bank_fsm == WRITING) || (bank_fsm == READING);
  assign in_alloc = (state == ALLOC);

  // Scan high-to-low so the lowest matching slot wins when tags are duplicated.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = CHROWS-1; k >= 0; k--) begin
      if (valid[k] && tags[k] == row_id) begin
        hit     = 1'b1;
        hit_idx = CHWIDTH'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_lookup = 1'b0;
    ptr_inc   = 1'b0;
    case (state)
      IDLE:   if (active) do_lookup = 1'b1;
      ALLOC:  if (sync) begin
                ptr_inc   = 1'b1;
                state_nxt = SYNCED;
              end
      SYNCED: if (!active)                      state_nxt = IDLE;
              else if (row_id != tags[c_row_id]) do_lookup = 1'b1;
      default: state_nxt = IDLE;
    endcase
    if (do_lookup) state_nxt = hit ? SYNCED : ALLOC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHROWS; i++) tags[i] <= '0;
      valid    <= '0;
      ptr      <= '0;
      c_row_id <= '0;
    end else begin
      if (do_lookup) begin
        if (hit) begin
          c_row_id <= hit_idx;
        end else begin
          c_row_id   <= ptr;
          tags[ptr]  <= row_id;
          valid[ptr] <= 1'b1;
        end
      end
      if (ptr_inc) ptr <= ptr + 1'b1;
    end
  end
endmodule

module mem_sync_top #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int CHWIDTH   = 6,
  parameter int ADDRWIDTH = 17
) (
  input  logic                                                clk,
  input  logic                                                reset_n,
  input  logic [BAWIDTH-1:0]                                  ba,
  input  logic [BGWIDTH-1:0]                                  bg,
  input  logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0][ADDRWIDTH-1:0] RowId,
  input  logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0][4:0]           BankFSM,
  input  logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0]                sync,
  output logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0][CHWIDTH-1:0]   cRowId,
  output logic                                                stall
);
  localparam int BANKGROUPS    = 2**BGWIDTH;
  localparam int BANKSPERGROUP = 2**BAWIDTH;

  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0] in_alloc;

  // reset_n is active-high despite its name.
  for (genvar g = 0; g < BANKGROUPS; g++) begin : g_grp
    for (genvar b = 0; b < BANKSPERGROUP; b++) begin : g_bank
      mem_sync_unit #(.CHWIDTH(CHWIDTH), .ADDRWIDTH(ADDRWIDTH)) u_unit (
        .clk      (clk),
        .rst      (reset_n),
        .row_id   (RowId[g][b]),
        .bank_fsm (BankFSM[g][b]),
        .sync     (sync[g][b]),
        .c_row_id (cRowId[g][b]),
        .in_alloc (in_alloc[g][b])
      );
    end
  end

  assign stall = in_alloc[bg][ba];
endmodule

// File: tb/tb_mem_sync_top.sv
// Directed bench for mem_sync_top: miss/hit, FIFO wrap, bank select, async reset.

module tb_mem_sync_top;
  localparam int BGW = 2, BAW = 2, CHW = 6, AW = 17;
  localparam logic [4:0] WR = 5'b10010, RD = 5'b01011;

  logic clk = 1'b0;
  logic reset_n;
  logic [BAW-1:0] ba;
  logic [BGW-1:0] bg;
  logic [3:0][3:0][AW-1:0]  RowId;
  logic [3:0][3:0][4:0]     BankFSM;
  logic [3:0][3:0]          sync;
  logic [3:0][3:0][CHW-1:0] cRowId;
  logic stall;

  int vectors = 0;
  int miscompares = 0;

  mem_sync_top #(.BGWIDTH(BGW), .BAWIDTH(BAW), .CHWIDTH(CHW), .ADDRWIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .ba(ba), .bg(bg), .RowId(RowId),
    .BankFSM(BankFSM), .sync(sync), .cRowId(cRowId), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b1; ba = '0; bg = '0;
    RowId = '0; BankFSM = '0; sync = '0;
    tick(); tick();
    check("rst_stall", 32'(stall), 0);
    check("rst_crow00", 32'(cRowId[0][0]), 0);
    #2 reset_n = 1'b0;

    // 1: first miss on bank 0, stall until sync
    BankFSM[0][0] = WR; RowId[0][0] = 17'h1234;
    tick();
    check("t1_stall", 32'(stall), 1);
    check("t1_crow", 32'(cRowId[0][0]), 0);
    tick(); tick(); tick();
    check("t1_stall_hold", 32'(stall), 1);
    sync[0][0] = 1'b1;
    tick();
    sync[0][0] = 1'b0;
    check("t1_stall_clr", 32'(stall), 0);

    // 2: re-access same row -> hit, no stall
    BankFSM[0][0] = 5'd0;
    tick();
    check("t2_idle_stall", 32'(stall), 0);
    BankFSM[0][0] = RD;
    tick();
    check("t2_hit_stall", 32'(stall), 0);
    check("t2_hit_crow", 32'(cRowId[0][0]), 0);

    // 3: fill slots 1..63
    for (int i = 1; i < 64; i++) begin
      BankFSM[0][0] = 5'd0;
      tick();
      BankFSM[0][0] = WR; RowId[0][0] = AW'(32'h100 + i);
      tick();
      check("t3_miss_stall", 32'(stall), 1);
      check("t3_miss_crow", 32'(cRowId[0][0]), i);
      sync[0][0] = 1'b1;
      tick();
      sync[0][0] = 1'b0;
      check("t3_sync_stall", 32'(stall), 0);
      BankFSM[0][0] = 5'd0;
      tick();
      BankFSM[0][0] = RD;
      tick();
      check("t3_hit_stall", 32'(stall), 0);
      check("t3_hit_crow", 32'(cRowId[0][0]), i);
    end

    // 4: wrap to slot 0, evicting 0x1234; re-access goes to slot 1
    BankFSM[0][0] = 5'd0;
    tick();
    BankFSM[0][0] = WR; RowId[0][0] = 17'h5555;
    tick();
    check("t4_wrap_stall", 32'(stall), 1);
    check("t4_wrap_crow", 32'(cRowId[0][0]), 0);
    sync[0][0] = 1'b1;
    tick();
    sync[0][0] = 1'b0;
    BankFSM[0][0] = 5'd0;
    tick();
    BankFSM[0][0] = RD; RowId[0][0] = 17'h1234;
    tick();
    check("t4_evict_stall", 32'(stall), 1);
    check("t4_evict_crow", 32'(cRowId[0][0]), 1);
    sync[0][0] = 1'b1;
    tick();
    sync[0][0] = 1'b0;
    check("t4_sync_stall", 32'(stall), 0);

    // 5: stall follows the selected bank only
    BankFSM[0][0] = 5'd0;
    BankFSM[2][3] = WR; RowId[2][3] = 17'h0777;
    tick();
    check("t5_unsel_stall", 32'(stall), 0);
    bg = 2'd2; ba = 2'd3;
    #1;
    check("t5_sel_stall", 32'(stall), 1);
    check("t5_crow23", 32'(cRowId[2][3]), 0);
    sync[0][0] = 1'b1;
    tick();
    sync[0][0] = 1'b0;
    check("t5_wrong_sync", 32'(stall), 1);
    sync[2][3] = 1'b1;
    tick();
    sync[2][3] = 1'b0;
    check("t5_sync_clr", 32'(stall), 0);
    check("t5_crow23_hold", 32'(cRowId[2][3]), 0);

    // 6: async reset while in ALLOC
    BankFSM[2][3] = 5'd0;
    tick();
    BankFSM[2][3] = WR; RowId[2][3] = 17'h0888;
    tick();
    check("t6_pre_stall", 32'(stall), 1);
    check("t6_pre_crow", 32'(cRowId[2][3]), 1);
    #2 reset_n = 1'b1;
    #1;
    check("t6_rst_stall", 32'(stall), 0);
    check("t6_rst_crow23", 32'(cRowId[2][3]), 0);
    check("t6_rst_crow00", 32'(cRowId[0][0]), 0);
    RowId[2][3] = 17'h0777;
    #2 reset_n = 1'b0;
    tick();
    check("t6_remiss_stall", 32'(stall), 1);
    check("t6_remiss_crow", 32'(cRowId[2][3]), 0);
    sync[2][3] = 1'b1;
    tick();
    sync[2][3] = 1'b0;
    check("t6_sync_clr", 32'(stall), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
